// File: rtl/mrd_source_stream.sv
// rtl/mrd_source_stream.sv - output streamer: reads the result bank and drives a framed valid/ready stream (optional MRD_SRC_CONJ_EN)
module mrd_source_stream #(
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 11,
    parameter int MAX_PTS    = 1200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [11:0]       start_dftpts,
    input  logic              start_inverse,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [17:0]       rd_real,
    input  logic [17:0]       rd_imag,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_sop,
    output logic              src_eop,
    output logic [17:0]       src_real,
    output logic [17:0]       src_imag,
    output logic [11:0]       src_dftpts,
    output logic              src_inverse
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CR_W  = 8;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [11:0]         r_n;
    logic                r_inv;
    logic [ADDR_W-1:0]   r_addr;
    logic [11:0]         r_out_cnt;
    logic [RD_LAT-1:0]   r_vpipe;
    logic [17:0]         r_fifo_re [FIFO_DEPTH];
    logic [17:0]         r_fifo_im [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_done;

    logic                w_start_ok;
    logic                w_valid;
    logic                w_pop;
    logic                w_push;
    logic [CR_W-1:0]     w_inflight;
    logic [CR_W-1:0]     w_used;
    logic                w_credit;
    logic                w_last_addr;
    logic                w_is_eop;
    logic                w_eop_hs;
    logic                w_rd_en;
    logic [17:0]         w_head_re;
    logic [17:0]         w_head_im;
    logic [17:0]         w_im_out;

    assign w_start_ok  = start && (start_dftpts != 12'd0) && (start_dftpts <= 12'(MAX_PTS));
    assign w_valid     = (r_count != '0);
    assign w_pop       = w_valid && src_ready;
    assign w_push      = r_vpipe[RD_LAT-1];
    assign w_used      = CR_W'(r_count) + w_inflight - CR_W'(w_pop);
    assign w_credit    = (w_used < CR_W'(FIFO_DEPTH));
    assign w_last_addr = (12'(r_addr) == (r_n - 12'd1));
    assign w_is_eop    = (r_out_cnt == (r_n - 12'd1));
    assign w_eop_hs    = w_pop && w_is_eop;
    assign w_head_re   = r_fifo_re[r_rd_ptr];
    assign w_head_im   = r_fifo_im[r_rd_ptr];

    // Count reads still travelling through the bank pipeline.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + CR_W'(r_vpipe[i]);
        end
    end

`ifdef MRD_SRC_CONJ_EN
    // Conjugate on the FIFO head; the most negative value saturates.
    always_comb begin
        w_im_out = w_head_im;
        if (r_inv) begin
            w_im_out = (w_head_im == 18'h20000) ? 18'h1FFFF : (18'd0 - w_head_im);
        end
    end
`else
    // Imag passes straight through.
    always_comb begin
        w_im_out = w_head_im;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and read issue; a read goes out only when a FIFO slot is guaranteed.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_credit) begin
                    w_rd_en = 1'b1;
                    if (w_last_addr) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_eop_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Frame parameters, read address and output beat counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_n       <= '0;
            r_inv     <= 1'b0;
            r_addr    <= '0;
            r_out_cnt <= '0;
        end else if ((r_state == S_IDLE) && w_start_ok) begin
            r_n       <= start_dftpts;
            r_inv     <= start_inverse;
            r_addr    <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_rd_en) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_out_cnt <= r_out_cnt + 12'd1;
            end
        end
    end

    // Done pulse lands in the first IDLE cycle after the eop handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_eop_hs;
        end
    end

    // Valid tags that follow each read through the bank latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vpipe <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
            r_vpipe[0] <= w_rd_en;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // FIFO storage; contents are only visible while the count says so.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_re[r_wr_ptr] <= rd_real;
            r_fifo_im[r_wr_ptr] <= rd_imag;
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign rd_en       = w_rd_en;
    assign rd_addr     = w_rd_en ? r_addr : '0;
    assign src_valid   = w_valid;
    assign src_sop     = w_valid && (r_out_cnt == 12'd0);
    assign src_eop     = w_valid && w_is_eop;
    assign src_real    = w_valid ? w_head_re : '0;
    assign src_imag    = w_valid ? w_im_out : '0;
    assign src_dftpts  = r_n;
    assign src_inverse = r_inv;

endmodule
